// File: rtl/timer_programmable.sv
// rtl/timer_programmable.sv - programmable one-shot/periodic up-counter timer
// Optional tick prescaler enabled by defining TIMER_PRESCALER_EN.
module timer_programmable #(
    parameter int WIDTH       = 16,
    parameter int PRESC_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   start,
    input  logic                   mode,
    input  logic [WIDTH-1:0]       load_value,
`ifdef TIMER_PRESCALER_EN
    input  logic [PRESC_WIDTH-1:0] prescale,
`endif
    output logic [WIDTH-1:0]       count,
    output logic                   busy,
    output logic                   saturation,
    output logic                   done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] load_lat;
    logic             mode_lat;
    logic             run_en;
    logic             tick;
    logic             terminal;

    assign run_en   = (state == S_RUN) && enable;
    assign terminal = (count == load_lat);

`ifdef TIMER_PRESCALER_EN
    logic [PRESC_WIDTH-1:0] presc_q;
    logic [PRESC_WIDTH-1:0] presc_lat;

    assign tick = run_en && (presc_q == presc_lat);

    // Prescaler only advances on enabled RUN cycles so a pause loses no partial ticks.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            presc_q   <= '0;
            presc_lat <= '0;
        end else if (start) begin
            presc_q   <= '0;
            presc_lat <= prescale;
        end else if (run_en) begin
            if (presc_q == presc_lat)
                presc_q <= '0;
            else
                presc_q <= presc_q + PRESC_WIDTH'(1);
        end
    end
`else
    assign tick = run_en;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            count      <= '0;
            load_lat   <= '0;
            mode_lat   <= 1'b0;
            busy       <= 1'b0;
            saturation <= 1'b0;
            done       <= 1'b0;
        end else if (start) begin
            // A start wins over a coincident terminal tick: no pulse, clean restart.
            state      <= S_RUN;
            count      <= '0;
            load_lat   <= load_value;
            mode_lat   <= mode;
            busy       <= 1'b1;
            saturation <= 1'b0;
            done       <= 1'b0;
        end else begin
            saturation <= 1'b0;
            case (state)
                S_RUN: begin
                    if (tick) begin
                        if (terminal) begin
                            saturation <= 1'b1;
                            if (mode_lat) begin
                                count <= '0;
                            end else begin
                                state <= S_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else begin
                            count <= count + WIDTH'(1);
                        end
                    end
                end
                S_DONE: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    count <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_programmable.sv
// tb/tb_timer_programmable.sv - directed self-checking bench for timer_programmable
module tb_timer_programmable;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        start;
    logic        mode;
    logic [15:0] load_value;
`ifdef TIMER_PRESCALER_EN
    logic [7:0]  prescale;
`endif
    logic [15:0] count;
    logic        busy;
    logic        saturation;
    logic        done;

    int tests = 0;
    int fails = 0;

    timer_programmable #(.WIDTH(16), .PRESC_WIDTH(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .start      (start),
        .mode       (mode),
        .load_value (load_value),
`ifdef TIMER_PRESCALER_EN
        .prescale   (prescale),
`endif
        .count      (count),
        .busy       (busy),
        .saturation (saturation),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic m, input logic [15:0] lv);
        mode       = m;
        load_value = lv;
        start      = 1'b1;
        step();
        start      = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        enable  = 1'b1;
        start   = 1'b1;
        mode    = 1'b1;
        load_value = 16'd5;
`ifdef TIMER_PRESCALER_EN
        prescale = 8'd0;
`endif
        step();
        step();
        start = 1'b0;
        tests++;
        if ({count, busy, saturation, done} !== 19'd0) begin
            fails++;
            $display("FAIL reset_outputs: got count=%0d busy=%b sat=%b done=%b, want all 0", count, busy, saturation, done);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) step();
        tests++;
        if (count !== 16'd0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_ignores_enable: got count=%0d busy=%b, want 0 0", count, busy);
        end
    endtask

    task automatic test_one_shot();
        enable = 1'b1;
        do_start(1'b0, 16'd9);
        tests++;
        if (count !== 16'd0 || busy !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL oneshot_start: got count=%0d busy=%b done=%b, want 0 1 0", count, busy, done);
        end
        for (int i = 0; i < 9; i++) step();
        tests++;
        if (count !== 16'd9 || saturation !== 1'b0) begin
            fails++;
            $display("FAIL oneshot_pre_terminal: got count=%0d sat=%b, want 9 0", count, saturation);
        end
        step();
        tests++;
        if (saturation !== 1'b1 || done !== 1'b1 || busy !== 1'b0 || count !== 16'd9) begin
            fails++;
            $display("FAIL oneshot_terminal: got sat=%b done=%b busy=%b count=%0d, want 1 1 0 9", saturation, done, busy, count);
        end
        enable = 1'b0;
        step();
        enable = 1'b1;
        step();
        step();
        tests++;
        if (saturation !== 1'b0 || done !== 1'b1 || count !== 16'd9) begin
            fails++;
            $display("FAIL oneshot_done_hold: got sat=%b done=%b count=%0d, want 0 1 9", saturation, done, count);
        end
        do_start(1'b0, 16'd3);
        tests++;
        if (done !== 1'b0 || busy !== 1'b1 || count !== 16'd0) begin
            fails++;
            $display("FAIL oneshot_restart: got done=%b busy=%b count=%0d, want 0 1 0", done, busy, count);
        end
    endtask

    task automatic test_periodic();
        int sat_n;
        int first_sat;
        int busy_low;
        logic [15:0] cnt_after;
        sat_n = 0; first_sat = -1; busy_low = 0; cnt_after = 16'hFFFF;
        enable = 1'b1;
        do_start(1'b1, 16'd255);
        for (int i = 1; i <= 512; i++) begin
            step();
            if (saturation) begin
                sat_n++;
                if (first_sat < 0) begin
                    first_sat = i;
                    cnt_after = count;
                end
            end
            if (!busy) busy_low++;
        end
        tests++;
        if (sat_n !== 2 || first_sat !== 256) begin
            fails++;
            $display("FAIL periodic_pulses: got %0d pulses first at %0d, want 2 at 256", sat_n, first_sat);
        end
        tests++;
        if (cnt_after !== 16'd0 || busy_low !== 0) begin
            fails++;
            $display("FAIL periodic_wrap_busy: got wrap count=%0d busy_low=%0d, want 0 0", cnt_after, busy_low);
        end
    endtask

    task automatic test_load_zero();
        int sat_n;
        sat_n = 0;
        enable = 1'b1;
        do_start(1'b1, 16'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            if (saturation && count == 16'd0) sat_n++;
        end
        tests++;
        if (sat_n !== 5) begin
            fails++;
            $display("FAIL zero_periodic: got %0d pulses in 5 ticks, want 5", sat_n);
        end
        do_start(1'b0, 16'd0);
        step();
        tests++;
        if (saturation !== 1'b1 || done !== 1'b1) begin
            fails++;
            $display("FAIL zero_oneshot_first: got sat=%b done=%b, want 1 1", saturation, done);
        end
        step();
        tests++;
        if (saturation !== 1'b0) begin
            fails++;
            $display("FAIL zero_oneshot_single: got sat=%b, want 0", saturation);
        end
    endtask

    task automatic test_pause();
        int sat_at;
        int held_bad;
        sat_at = -1; held_bad = 0;
        enable = 1'b1;
        do_start(1'b1, 16'd9);
        for (int i = 0; i < 5; i++) step();
        tests++;
        if (count !== 16'd5) begin
            fails++;
            $display("FAIL pause_pre: got count=%0d, want 5", count);
        end
        enable = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            if (count !== 16'd5 || saturation !== 1'b0) held_bad++;
        end
        enable = 1'b1;
        for (int i = 13; i <= 30; i++) begin
            step();
            if (saturation && sat_at < 0) sat_at = i;
        end
        tests++;
        if (held_bad !== 0 || sat_at !== 17) begin
            fails++;
            $display("FAIL pause_delay: got hold errors=%0d sat at %0d, want 0 at 17", held_bad, sat_at);
        end
    endtask

    task automatic test_start_collision();
        enable = 1'b1;
        do_start(1'b1, 16'd3);
        for (int i = 0; i < 3; i++) step();
        tests++;
        if (count !== 16'd3) begin
            fails++;
            $display("FAIL collision_pre: got count=%0d, want 3", count);
        end
        do_start(1'b1, 16'd6);
        tests++;
        if (saturation !== 1'b0 || count !== 16'd0) begin
            fails++;
            $display("FAIL collision_start: got sat=%b count=%0d, want 0 0", saturation, count);
        end
        load_value = 16'd1;
        mode = 1'b0;
        for (int i = 0; i < 6; i++) step();
        tests++;
        if (count !== 16'd6 || saturation !== 1'b0) begin
            fails++;
            $display("FAIL collision_newload: got count=%0d sat=%b, want 6 0", count, saturation);
        end
        step();
        tests++;
        if (saturation !== 1'b1 || count !== 16'd0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL collision_isolation: got sat=%b count=%0d busy=%b, want 1 0 1", saturation, count, busy);
        end
    endtask

    task automatic test_reset_run();
        enable = 1'b1;
        do_start(1'b1, 16'd200);
        for (int i = 0; i < 100; i++) step();
        tests++;
        if (count !== 16'd100) begin
            fails++;
            $display("FAIL rst_run_pre: got count=%0d, want 100", count);
        end
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        tests++;
        if ({count, busy, saturation, done} !== 19'd0) begin
            fails++;
            $display("FAIL rst_run_outputs: got count=%0d busy=%b sat=%b done=%b, want all 0", count, busy, saturation, done);
        end
        for (int i = 0; i < 5; i++) step();
        tests++;
        if (count !== 16'd0 || busy !== 1'b0 || saturation !== 1'b0) begin
            fails++;
            $display("FAIL rst_run_idle: got count=%0d busy=%b sat=%b, want 0 0 0", count, busy, saturation);
        end
    endtask

`ifdef TIMER_PRESCALER_EN
    task automatic test_prescale();
        int sat_at;
        sat_at = -1;
        enable = 1'b1;
        prescale = 8'd3;
        do_start(1'b1, 16'd4);
        prescale = 8'd0;
        for (int i = 1; i <= 3; i++) step();
        tests++;
        if (count !== 16'd0) begin
            fails++;
            $display("FAIL presc_hold: got count=%0d, want 0", count);
        end
        step();
        tests++;
        if (count !== 16'd1) begin
            fails++;
            $display("FAIL presc_first_tick: got count=%0d, want 1", count);
        end
        for (int i = 5; i <= 24; i++) begin
            step();
            if (saturation && sat_at < 0) sat_at = i;
        end
        tests++;
        if (sat_at !== 20) begin
            fails++;
            $display("FAIL presc_period: got sat at %0d, want 20", sat_at);
        end
    endtask
`endif

    initial begin
        reset_n = 1'b0; enable = 1'b0; start = 1'b0; mode = 1'b0; load_value = '0;
`ifdef TIMER_PRESCALER_EN
        prescale = '0;
`endif
        test_reset();
        test_one_shot();
        test_periodic();
        test_load_zero();
        test_pause();
        test_start_collision();
        test_reset_run();
`ifdef TIMER_PRESCALER_EN
        test_prescale();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
